// File: rtl/mac_kbd_link.sv
// Mac keyboard-line engine: generates kbdclk, shifts commands in from the Mac and shifts queued replies out.
// Optional reply timeout is enabled with `define KBD_REPLY_TIMEOUT_EN (sends NULL_BYTE when no reply arrives).
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | line released, kbdclk high, waiting for the Mac to pull data low
//  RX_CMD     | clocking 8 command bits in from the Mac, MSB first
//  WAIT_REPLY | command delivered, waiting for data high and a queued reply
//  TX_REPLY   | clocking 8 reply bits out to the Mac, MSB first
module mac_kbd_link #(
  parameter int         HALF_PERIOD   = 1300,
  parameter int         FIFO_AW       = 2,
  parameter logic [7:0] NULL_BYTE     = 8'h7B,
  parameter int         TIMEOUT_TICKS = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             kbddat_i,
  output logic             kbdclk,
  output logic             kbddata_o,
  output logic [7:0]       cmd_data,
  output logic             cmd_strobe,
  input  logic [7:0]       key_data,
  input  logic             key_strobe,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow
);

  localparam int                CW         = $clog2(HALF_PERIOD + 1);
  localparam int                DEPTH      = 1 << FIFO_AW;
  localparam logic [CW-1:0]     HALF_TC    = CW'(HALF_PERIOD);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [FIFO_AW:0]  LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  PTR_ONE    = (FIFO_AW + 1)'(1);

  if (HALF_PERIOD < 1 || FIFO_AW < 1 || TIMEOUT_TICKS < 2) begin : g_param_check
    $error("mac_kbd_link: HALF_PERIOD>=1, FIFO_AW>=1 and TIMEOUT_TICKS>=2 required");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RX_CMD     = 2'd1,
    WAIT_REPLY = 2'd2,
    TX_REPLY   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    tick_cnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic [7:0]       txreg;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push_req, push, push_drop, pop;

  logic             shifting, half_tc, edge_rise, last_bit;

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LEVEL_FULL);

  assign shifting  = (state == RX_CMD) || (state == TX_REPLY);
  assign half_tc   = (tick_cnt == HALF_TC);
  assign edge_rise = shifting && half_tc && !kbdclk;
  assign last_bit  = (bitcnt == 3'd7);

`ifdef KBD_REPLY_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TIMER_TC = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  logic [TW-1:0] timer;
  logic          load_null;

  // Counts only while the Mac is ready and nothing is queued; any state change restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (ce) begin
      if (state != WAIT_REPLY || state_nxt != state)
        timer <= '0;
      else if (kbddat_i)
        timer <= timer + TMR_ONE;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
`ifdef KBD_REPLY_TIMEOUT_EN
    load_null = 1'b0;
`endif
    case (state)
      IDLE:       if (!kbddat_i) state_nxt = RX_CMD;
      RX_CMD:     if (edge_rise && last_bit) state_nxt = WAIT_REPLY;
      WAIT_REPLY: begin
        if (kbddat_i && !fifo_empty) begin
          pop       = ce;
          state_nxt = TX_REPLY;
        end
`ifdef KBD_REPLY_TIMEOUT_EN
        else if (kbddat_i && timer == TIMER_TC) begin
          load_null = ce;
          state_nxt = TX_REPLY;
        end
`endif
      end
      TX_REPLY:   if (edge_rise && last_bit) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      kbdclk     <= 1'b1;
      kbddata_o  <= 1'b1;
      bitcnt     <= '0;
      shreg      <= '0;
      txreg      <= NULL_BYTE;
      cmd_data   <= '0;
      cmd_strobe <= 1'b0;
    end else begin
      cmd_strobe <= 1'b0;
      if (ce) begin
        state <= state_nxt;
        case (state)
          IDLE: begin
            tick_cnt  <= '0;
            kbdclk    <= 1'b1;
            kbddata_o <= 1'b1;
            bitcnt    <= '0;
          end
          RX_CMD, TX_REPLY: begin
            if (half_tc) begin
              tick_cnt <= '0;
              kbdclk   <= ~kbdclk;
              if (kbdclk) begin
                // falling edge: Mac data is sampled, reply data is launched
                if (state == RX_CMD)
                  shreg <= {shreg[6:0], kbddat_i};
                else
                  kbddata_o <= txreg[3'd7 - bitcnt];
              end else begin
                bitcnt <= bitcnt + 3'd1;
                if (state == RX_CMD && last_bit) begin
                  cmd_data   <= shreg;
                  cmd_strobe <= 1'b1;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_ONE;
            end
          end
          WAIT_REPLY: begin
            tick_cnt <= '0;
            kbdclk   <= 1'b1;
            bitcnt   <= '0;
            if (pop)
              txreg <= mem[rd_ptr[FIFO_AW-1:0]];
`ifdef KBD_REPLY_TIMEOUT_EN
            else if (load_null)
              txreg <= NULL_BYTE;
`endif
          end
          default: begin
            tick_cnt <= '0;
            kbdclk   <= 1'b1;
          end
        endcase
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same tick;
  // an empty FIFO never pops, so a same-tick push is popped one tick later.
  assign push_req  = ce && key_strobe && !reset;
  assign push      = push_req && (!fifo_full || pop);
  assign push_drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_drop)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[FIFO_AW-1:0]] <= key_data;
  end

endmodule

// File: tb/tb_mac_kbd_link.sv
// Directed bench for mac_kbd_link: acts as the Mac side of the line and as the keyboard model.
// Builds with or without KBD_REPLY_TIMEOUT_EN; the timeout scenario adapts to the build.
module tb_mac_kbd_link;

  localparam int HP = 9;
  localparam int TO = 100;

  logic       clk, reset, ce, kbddat_i;
  logic       kbdclk, kbddata_o, cmd_strobe, overflow;
  logic [7:0] cmd_data, key_data;
  logic       key_strobe;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int strobe_cnt = 0;

  mac_kbd_link #(
    .HALF_PERIOD(HP), .FIFO_AW(2), .NULL_BYTE(8'h7B), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .kbddat_i(kbddat_i),
    .kbdclk(kbdclk), .kbddata_o(kbddata_o), .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
    .key_data(key_data), .key_strobe(key_strobe), .fifo_level(fifo_level), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // clock enable on every other clk edge
  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clk);
      ce = ~ce;
    end
  end

  always @(posedge clk) if (cmd_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ce(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (ce !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic wait_lvl(input logic lvl, output int ticks, output bit ok);
    ticks = 0;
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      if (ce === 1'b1) ticks++;
      #1;
      if (kbdclk === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    key_data = b;
    key_strobe = 1'b1;
    wait_ce(1);
    key_strobe = 1'b0;
  endtask

  // Mac sends a command; stop_after>0 abandons the transfer after that many falling edges.
  task automatic mac_send(input logic [7:0] b, input int stop_after);
    int t, tot;
    bit ok;
    kbddat_i = 1'b0;
    wait_ce(2);
    tot = 0;
    for (int i = 7; i >= 0; i--) begin
      kbddat_i = b[i];
      wait_lvl(1'b0, t, ok);
      check("rx_fall_seen", ok, 1);
      if (i < 7) tot += t;
      if (stop_after == 8 - i) return;
      wait_lvl(1'b1, t, ok);
      check("rx_rise_seen", ok, 1);
      tot += t;
    end
    check("rx_span_ce", tot, 15 * (HP + 1));
    check("rx_cmd_data", cmd_data, b);
  endtask

  // Mac releases data and reads one reply; first_fall>0 checks ce ticks from release to first fall.
  task automatic mac_recv(input logic [7:0] exp, input int first_fall);
    logic [7:0] got;
    int t;
    bit ok;
    kbddat_i = 1'b1;
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      wait_lvl(1'b0, t, ok);
      check("tx_fall_seen", ok, 1);
      if (i == 7 && first_fall > 0) check("tx_first_fall", t, first_fall);
      got[i] = kbddata_o;
      wait_lvl(1'b1, t, ok);
      check("tx_rise_seen", ok, 1);
    end
    check("tx_byte", got, exp);
    wait_ce(2);
    check("tx_end_clk", kbdclk, 1);
    check("tx_end_dat", kbddata_o, 1);
  endtask

  logic [7:0] cmds [4];
  logic [7:0] exp5 [4];
  int  t6;
  bit  ok6;

  initial begin
    cmds[0] = 8'hA4; cmds[1] = 8'h3C; cmds[2] = 8'hFE; cmds[3] = 8'h00;
    exp5[0] = 8'h22; exp5[1] = 8'h33; exp5[2] = 8'h44; exp5[3] = 8'h55;
    reset = 1'b1; kbddat_i = 1'b1; key_data = '0; key_strobe = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_kbdclk", kbdclk, 1);
    check("rst_kbddata", kbddata_o, 1);
    check("rst_cmd_data", cmd_data, 0);
    check("rst_strobe", cmd_strobe, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);

    // T1: command 0x10
    mac_send(8'h10, 0);
    wait_ce(2);
    check("t1_strobes", strobe_cnt, 1);
    wait_ce(30);
    check("t1_wait_clk", kbdclk, 1);

    // T2: single reply 0x5A
    push(8'h5A);
    check("t2_level", fifo_level, 1);
    mac_recv(8'h5A, HP + 2);
    check("t2_level_after", fifo_level, 0);

    // T3: overfill with 0x01..0x05, then drain
    for (int k = 1; k <= 5; k++) push(8'(k));
    check("t3_level", fifo_level, 4);
    check("t3_overflow", overflow, 1);
    for (int k = 0; k < 4; k++) begin
      mac_send(cmds[k], 0);
      mac_recv(8'(k + 1), HP + 2);
    end
    check("t3_level_after", fifo_level, 0);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_strobes", strobe_cnt, 5);

    // T4: reset in the middle of bit 4 of a command
    push(8'h77);
    check("t4_level_pre", fifo_level, 1);
    mac_send(8'hB6, 4);
    wait_ce(3);
    @(negedge clk);
    reset = 1'b1;
    kbddat_i = 1'b1;
    @(posedge clk);
    #1;
    check("t4_kbdclk", kbdclk, 1);
    check("t4_kbddata", kbddata_o, 1);
    check("t4_level", fifo_level, 0);
    check("t4_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_ce(25);
    check("t4_no_strobe", strobe_cnt, 5);
    check("t4_idle_clk", kbdclk, 1);
    mac_send(8'hC2, 0);
    wait_ce(1);
    check("t4_strobes", strobe_cnt, 6);

    // T5: full FIFO, push and pop on the same tick
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    check("t5_level_full", fifo_level, 4);
    check("t5_overflow_pre", overflow, 0);
    @(negedge clk);
    key_data = 8'h55;
    key_strobe = 1'b1;
    kbddat_i = 1'b1;
    wait_ce(1);
    key_strobe = 1'b0;
    check("t5_level_pushpop", fifo_level, 4);
    check("t5_overflow", overflow, 0);
    mac_recv(8'h11, 0);
    for (int k = 0; k < 4; k++) begin
      mac_send(cmds[k], 0);
      mac_recv(exp5[k], HP + 2);
    end
    check("t5_overflow_end", overflow, 0);

    // push into an empty FIFO while the Mac is already waiting
    mac_send(8'h02, 0);
    kbddat_i = 1'b1;
    wait_ce(5);
    check("t7_wait_clk", kbdclk, 1);
    check("t7_level", fifo_level, 0);
    push(8'h9C);
    mac_recv(8'h9C, 0);

    // T6: no reply queued
    mac_send(8'h04, 0);
`ifdef KBD_REPLY_TIMEOUT_EN
    mac_recv(8'h7B, TO + HP + 1);
`else
    kbddat_i = 1'b1;
    wait_lvl(1'b0, t6, ok6);
    check("t6_no_timeout", ok6, 0);
    check("t6_clk_high", kbdclk, 1);
`endif
    check("final_strobes", strobe_cnt, 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
